// File: rtl/i2c_line_sync.sv
// Two-flop synchronizers for SCL/SDA plus START, STOP and SCL edge detection.
// Events are held off for three cycles after reset so the idle-high reset value never fakes an edge.
module i2c_line_sync (
    input  logic clock,
    input  logic reset,
    input  logic scl_pad_i,
    input  logic sda_pad_i,
    output logic sda_o,
    output logic start_o,
    output logic stop_o,
    output logic scl_rise_o,
    output logic scl_fall_o
);

    logic       scl_s1_q, scl_s2_q, scl_prev_q;
    logic       sda_s1_q, sda_s2_q, sda_prev_q;
    logic [1:0] warm_q, warm_d;
    logic       en;

    always_comb begin
        warm_d = warm_q;
        if (warm_q != 2'd3) warm_d = warm_q + 2'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            scl_s1_q   <= 1'b1;
            scl_s2_q   <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_s1_q   <= 1'b1;
            sda_s2_q   <= 1'b1;
            sda_prev_q <= 1'b1;
            warm_q     <= 2'd0;
        end else begin
            scl_s1_q   <= scl_pad_i;
            scl_s2_q   <= scl_s1_q;
            scl_prev_q <= scl_s2_q;
            sda_s1_q   <= sda_pad_i;
            sda_s2_q   <= sda_s1_q;
            sda_prev_q <= sda_s2_q;
            warm_q     <= warm_d;
        end
    end

    assign en         = (warm_q == 2'd3);
    assign sda_o      = sda_s2_q;
    assign scl_rise_o = en &  scl_s2_q & ~scl_prev_q;
    assign scl_fall_o = en & ~scl_s2_q &  scl_prev_q;
    // SDA edges only count as conditions while SCL is stably high.
    assign start_o    = en & scl_s2_q & scl_prev_q &  sda_prev_q & ~sda_s2_q;
    assign stop_o     = en & scl_s2_q & scl_prev_q & ~sda_prev_q &  sda_s2_q;

endmodule

// File: rtl/setting_reg.sv
// Settings-bus register: captures the low WIDTH bits of set_data when the strobe
// addresses MY_ADDR and pulses changed for one cycle alongside the new value.
module setting_reg #(
    parameter logic [7:0] MY_ADDR = 8'd0,
    parameter int         WIDTH   = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             strobe,
    input  logic [7:0]       addr,
    input  logic [31:0]      in_data,
    output logic [WIDTH-1:0] out_data,
    output logic             changed
);

    logic [WIDTH-1:0] out_q, out_d;
    logic             changed_q, changed_d;

    // Upper data bits are legitimately ignored for narrow registers.
    logic unused_in;
    assign unused_in = ^in_data;

    always_comb begin
        out_d     = out_q;
        changed_d = 1'b0;
        if (strobe && (addr == MY_ADDR)) begin
            out_d     = in_data[WIDTH-1:0];
            changed_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_q     <= '0;
            changed_q <= 1'b0;
        end else begin
            out_q     <= out_d;
            changed_q <= changed_d;
        end
    end

    assign out_data = out_q;
    assign changed  = changed_q;

endmodule

// File: rtl/simple_i2c_slave.sv
// I2C target exposing a 16 x 8-bit register bank, shared with the settings bus.
// Pointer-addressed writes, auto-incrementing reads, repeated START; never stretches SCL.
module simple_i2c_slave #(
    parameter int         BASE     = 0,
    parameter logic [6:0] I2C_ADDR = 7'h50
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    output logic [31:0] readback,
    output logic        busy,
    output logic        i2c_wr_stb,
    output logic [3:0]  i2c_wr_index,
    input  logic        scl_pad_i,
    input  logic        sda_pad_i,
    output logic        sda_pad_o,
    output logic        sda_padoen_o,
    output logic [31:0] debug
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ADDR    = 3'd1;
    localparam logic [2:0] S_ACK_OUT = 3'd2;
    localparam logic [2:0] S_RX      = 3'd3;
    localparam logic [2:0] S_TX      = 3'd4;
    localparam logic [2:0] S_ACK_IN  = 3'd5;
    localparam logic [2:0] S_WAIT    = 3'd6;

    logic [11:0] host_wr_bits;
    logic        host_wr_stb;
    logic [3:0]  sel_bits;
    logic        sel_stb;

    setting_reg #(.MY_ADDR(8'(BASE)), .WIDTH(12)) u_sr_wr (
        .clock(clock), .reset(reset), .strobe(set_stb), .addr(set_addr),
        .in_data(set_data), .out_data(host_wr_bits), .changed(host_wr_stb)
    );

    setting_reg #(.MY_ADDR(8'(BASE + 1)), .WIDTH(4)) u_sr_sel (
        .clock(clock), .reset(reset), .strobe(set_stb), .addr(set_addr),
        .in_data(set_data), .out_data(sel_bits), .changed(sel_stb)
    );

    logic sda_s, start_det, stop_det, scl_rise, scl_fall;

    i2c_line_sync u_sync (
        .clock(clock), .reset(reset), .scl_pad_i(scl_pad_i), .sda_pad_i(sda_pad_i),
        .sda_o(sda_s), .start_o(start_det), .stop_o(stop_det),
        .scl_rise_o(scl_rise), .scl_fall_o(scl_fall)
    );

    logic [2:0]  state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [3:0]  ptr_q, ptr_d;
    logic        rw_q, rw_d;
    logic        first_q, first_d;
    logic        ack_drv_q, ack_drv_d;
    logic        oen_q, oen_d;
    logic        busy_q, busy_d;
    logic        wr_stb_q, wr_stb_d;
    logic [3:0]  wr_index_q, wr_index_d;
    logic        sticky_q, sticky_d;
    logic [31:0] readback_q, readback_d;
    logic [7:0]  bank_q [16];
    logic [7:0]  bank_d [16];
    logic [7:0]  rx_byte;
    logic        i2c_we;

    assign rx_byte = {shift_q[6:0], sda_s};

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        rw_d       = rw_q;
        first_d    = first_q;
        ack_drv_d  = ack_drv_q;
        oen_d      = oen_q;
        busy_d     = busy_q;
        wr_stb_d   = 1'b0;
        wr_index_d = wr_index_q;
        i2c_we     = 1'b0;

        if (start_det) begin
            state_d   = S_ADDR;
            bit_cnt_d = 4'd0;
            oen_d     = 1'b1;
            busy_d    = 1'b0;
            ack_drv_d = 1'b0;
        end else if (stop_det) begin
            state_d   = S_IDLE;
            oen_d     = 1'b1;
            busy_d    = 1'b0;
            ack_drv_d = 1'b0;
        end else begin
            case (state_q)
                S_ADDR, S_RX: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            if (state_q == S_ADDR) begin
                                if (rx_byte[7:1] == I2C_ADDR) begin
                                    state_d = S_ACK_OUT;
                                    busy_d  = 1'b1;
                                    rw_d    = rx_byte[0];
                                    first_d = 1'b1;
                                end else begin
                                    state_d = S_IDLE;
                                end
                            end else begin
                                state_d = S_ACK_OUT;
                                if (first_q) begin
                                    ptr_d   = rx_byte[3:0];
                                    first_d = 1'b0;
                                end else begin
                                    i2c_we     = 1'b1;
                                    wr_stb_d   = 1'b1;
                                    wr_index_d = ptr_q;
                                    ptr_d      = ptr_q + 4'd1;
                                end
                            end
                        end
                    end
                end
                // ACK occupies the low-high-low window between two SCL falls.
                S_ACK_OUT: begin
                    if (scl_fall) begin
                        if (!ack_drv_q) begin
                            oen_d     = 1'b0;
                            ack_drv_d = 1'b1;
                        end else begin
                            ack_drv_d = 1'b0;
                            bit_cnt_d = 4'd0;
                            if (rw_q) begin
                                state_d = S_TX;
                                shift_d = bank_q[ptr_q];
                                oen_d   = bank_q[ptr_q][7];
                            end else begin
                                state_d = S_RX;
                                oen_d   = 1'b1;
                            end
                        end
                    end
                end
                S_TX: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            oen_d     = 1'b1;
                            state_d   = S_ACK_IN;
                            bit_cnt_d = 4'd0;
                        end else begin
                            shift_d = {shift_q[6:0], 1'b0};
                            oen_d   = shift_q[6];
                        end
                    end
                end
                S_ACK_IN: begin
                    if (scl_rise) begin
                        if (sda_s) state_d = S_WAIT;
                        else       ptr_d   = ptr_q + 4'd1;
                    end else if (scl_fall) begin
                        state_d   = S_TX;
                        bit_cnt_d = 4'd0;
                        shift_d   = bank_q[ptr_q];
                        oen_d     = bank_q[ptr_q][7];
                    end
                end
                default: ;
            endcase
        end

        // Host write is applied last so it wins a same-register collision.
        bank_d = bank_q;
        if (i2c_we) bank_d[ptr_q] = rx_byte;
        if (host_wr_stb) bank_d[host_wr_bits[11:8]] = host_wr_bits[7:0];

        sticky_d = sticky_q;
        if (sel_stb) sticky_d = 1'b0;
        if (i2c_we)  sticky_d = 1'b1;

        readback_d = {16'd0, 6'd0, sticky_q, busy_q, bank_q[sel_bits]};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'd0;
            ptr_q      <= 4'd0;
            rw_q       <= 1'b0;
            first_q    <= 1'b0;
            ack_drv_q  <= 1'b0;
            oen_q      <= 1'b1;
            busy_q     <= 1'b0;
            wr_stb_q   <= 1'b0;
            wr_index_q <= 4'd0;
            sticky_q   <= 1'b0;
            readback_q <= 32'd0;
            for (int i = 0; i < 16; i++) bank_q[i] <= 8'd0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            rw_q       <= rw_d;
            first_q    <= first_d;
            ack_drv_q  <= ack_drv_d;
            oen_q      <= oen_d;
            busy_q     <= busy_d;
            wr_stb_q   <= wr_stb_d;
            wr_index_q <= wr_index_d;
            sticky_q   <= sticky_d;
            readback_q <= readback_d;
            for (int i = 0; i < 16; i++) bank_q[i] <= bank_d[i];
        end
    end

    assign readback     = readback_q;
    assign busy         = busy_q;
    assign i2c_wr_stb   = wr_stb_q;
    assign i2c_wr_index = wr_index_q;
    assign sda_pad_o    = 1'b0;
    assign sda_padoen_o = oen_q;
    assign debug        = {13'd0, state_q, bit_cnt_q, ptr_q, shift_q};

endmodule
